// File: rtl/div_pipe_if.sv
// div_pipe_if: request/result bus of the pipelined divider.
//   master : drives operations (in_*) and result back-pressure (out_ready)
//   slave  : the divider; returns in_ready and the result bus (out_*)
//   in_valid/in_ready/in_signed/dividend/divisor/in_tag    operation handshake
//   out_valid/out_ready/quotient/remainder/out_tag/div_by_zero  result handshake
interface div_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [TAG_W-1:0] out_tag;
    logic             div_by_zero;

    modport master (
        output in_valid, in_signed, dividend, divisor, in_tag, out_ready,
        input  in_ready, out_valid, quotient, remainder, out_tag, div_by_zero
    );

    modport slave (
        input  in_valid, in_signed, dividend, divisor, in_tag, out_ready,
        output in_ready, out_valid, quotient, remainder, out_tag, div_by_zero
    );
endinterface

// File: rtl/div_pipe.sv
// div_pipe: fully pipelined restoring divider, signed or unsigned per operation.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; flushes every in-flight operation
//   bus    div_pipe_if slave port (operation in, result out, valid/ready both ways)
// Pipeline: stage 0 captures signs and operand magnitudes, stages 1..WIDTH each
// resolve one quotient bit MSB first, then an output register applies the sign
// fix-up and the zero-divisor override. The whole pipe moves on a single
// advance enable, so a stalled output freezes every stage behind it.
module div_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    div_pipe_if.slave bus
);
    localparam int NS = WIDTH + 1;  // stage 0 plus WIDTH iteration stages

    logic advance;

    logic [NS-1:0]    vld_q, vld_d;
    logic [NS-1:0]    qneg_q, qneg_d;
    logic [NS-1:0]    rneg_q, rneg_d;
    logic [NS-1:0]    dz_q, dz_d;
    // Partial remainder is always below the divisor magnitude, so its top
    // (WIDTH+1-th) bit is zero between stages and only exists in the trial value.
    logic [WIDTH-1:0] prem_q [NS];
    logic [WIDTH-1:0] prem_d [NS];
    // Unconsumed dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [WIDTH-1:0] shq_q  [NS];
    logic [WIDTH-1:0] shq_d  [NS];
    logic [WIDTH-1:0] dvs_q  [NS];
    logic [WIDTH-1:0] dvs_d  [NS];
    logic [TAG_W-1:0] tag_q  [NS];
    logic [TAG_W-1:0] tag_d  [NS];

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [TAG_W-1:0] otag_q, otag_d;
    logic             odz_q, odz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] q_mag, r_mag;

    assign advance      = bus.out_ready | ~out_vld_q;
    assign bus.in_ready = advance;

    always_comb begin
        vld_d  = '0;
        qneg_d = '0;
        rneg_d = '0;
        dz_d   = '0;
        for (int k = 0; k < NS; k++) begin
            prem_d[k] = '0;
            shq_d[k]  = '0;
            dvs_d[k]  = '0;
            tag_d[k]  = '0;
        end

        a_neg     = bus.in_signed & bus.dividend[WIDTH-1];
        b_neg     = bus.in_signed & bus.divisor[WIDTH-1];
        vld_d[0]  = bus.in_valid;
        qneg_d[0] = a_neg ^ b_neg;
        rneg_d[0] = a_neg;
        dz_d[0]   = (bus.divisor == '0);
        prem_d[0] = '0;
        // Negating the most-negative value yields itself, which is exactly its
        // magnitude when read as unsigned.
        shq_d[0]  = a_neg ? -bus.dividend : bus.dividend;
        dvs_d[0]  = b_neg ? -bus.divisor : bus.divisor;
        tag_d[0]  = bus.in_tag;

        for (int k = 1; k < NS; k++) begin : iter
            logic [WIDTH:0] trial;
            logic [WIDTH:0] diff;
            trial = {prem_q[k-1], shq_q[k-1][WIDTH-1]};
            diff  = trial - {1'b0, dvs_q[k-1]};
            if (!diff[WIDTH]) begin
                prem_d[k] = diff[WIDTH-1:0];
                shq_d[k]  = {shq_q[k-1][WIDTH-2:0], 1'b1};
            end else begin
                prem_d[k] = trial[WIDTH-1:0];
                shq_d[k]  = {shq_q[k-1][WIDTH-2:0], 1'b0};
            end
            vld_d[k]  = vld_q[k-1];
            qneg_d[k] = qneg_q[k-1];
            rneg_d[k] = rneg_q[k-1];
            dz_d[k]   = dz_q[k-1];
            dvs_d[k]  = dvs_q[k-1];
            tag_d[k]  = tag_q[k-1];
        end

        // A zero divisor leaves the remainder equal to |dividend| and every
        // quotient bit set; only the quotient sign fix-up must be bypassed.
        q_mag     = shq_q[WIDTH];
        r_mag     = prem_q[WIDTH];
        out_vld_d = vld_q[WIDTH];
        quo_d     = dz_q[WIDTH] ? '1 : (qneg_q[WIDTH] ? -q_mag : q_mag);
        rem_d     = rneg_q[WIDTH] ? -r_mag : r_mag;
        otag_d    = tag_q[WIDTH];
        odz_d     = dz_q[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            qneg_q    <= '0;
            rneg_q    <= '0;
            dz_q      <= '0;
            for (int k = 0; k < NS; k++) begin
                prem_q[k] <= '0;
                shq_q[k]  <= '0;
                dvs_q[k]  <= '0;
                tag_q[k]  <= '0;
            end
            out_vld_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            otag_q    <= '0;
            odz_q     <= 1'b0;
        end else if (advance) begin
            vld_q     <= vld_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            for (int k = 0; k < NS; k++) begin
                prem_q[k] <= prem_d[k];
                shq_q[k]  <= shq_d[k];
                dvs_q[k]  <= dvs_d[k];
                tag_q[k]  <= tag_d[k];
            end
            out_vld_q <= out_vld_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            otag_q    <= otag_d;
            odz_q     <= odz_d;
        end
    end

    assign bus.out_valid   = out_vld_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.out_tag     = otag_q;
    assign bus.div_by_zero = odz_q;
endmodule

// File: tb/tb_div_pipe.sv
// tb_div_pipe: directed and streamed checks of div_pipe at WIDTH=32 and WIDTH=8.
// Latency is counted in rising edges, the accepting edge being edge 1.
module tb_div_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    div_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();
    div_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();

    div_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    div_pipe #(.WIDTH(8),  .TAG_W(4)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference: language-level division; {dz, quotient, remainder}.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb;
        logic [31:0] q, r;
        logic dz;
        dz = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {dz, q, r};
    endfunction

    task automatic run32(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [3:0] tg,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int cyc;
        @(negedge clk);
        b32.in_valid  = 1'b1;
        b32.dividend  = a;
        b32.divisor   = b;
        b32.in_signed = sgn;
        b32.in_tag    = tg;
        b32.out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, 64'(b32.in_ready), 64'd1);
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        cyc = 1;
        while (!b32.out_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'd34);
        chk({nm, "_quot"}, 64'(b32.quotient), 64'(eq));
        chk({nm, "_rem"},  64'(b32.remainder), 64'(er));
        chk({nm, "_tag"},  64'(b32.out_tag), 64'(tg));
        chk({nm, "_dz"},   64'(b32.div_by_zero), 64'(edz));
    endtask

    task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic [7:0] eq, input logic [7:0] er);
        int cyc;
        @(negedge clk);
        b8.in_valid  = 1'b1;
        b8.dividend  = a;
        b8.divisor   = b;
        b8.in_signed = sgn;
        b8.in_tag    = 4'h9;
        b8.out_ready = 1'b1;
        @(posedge clk);
        #1 b8.in_valid = 1'b0;
        cyc = 1;
        while (!b8.out_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'd10);
        chk({nm, "_quot"}, 64'(b8.quotient), 64'(eq));
        chk({nm, "_rem"},  64'(b8.remainder), 64'(er));
        chk({nm, "_tag"},  64'(b8.out_tag), 64'h9);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra [40];
        logic [31:0] rb [40];
        logic        rs [40];
        logic [68:0] sb [$];
        logic [68:0] e;
        logic        held;
        logic [31:0] hq, hr;
        logic [3:0]  ht;
        logic        hdz;
        int          sent, got, cyc, nv;

        rst_n = 1'b0;
        b32.in_valid = 1'b0; b32.in_signed = 1'b0; b32.dividend = '0; b32.divisor = '0;
        b32.in_tag = '0; b32.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_signed = 1'b0; b8.dividend = '0; b8.divisor = '0;
        b8.in_tag = '0; b8.out_ready = 1'b1;

        #1;
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_quot",      64'(b32.quotient), 64'd0);
        chk("rst_rem",       64'(b32.remainder), 64'd0);
        chk("rst_tag",       64'(b32.out_tag), 64'd0);
        chk("rst_dz",        64'(b32.div_by_zero), 64'd0);
        chk("rst_in_ready",  64'(b32.in_ready), 64'd1);
        chk("rst8_out_valid", 64'(b8.out_valid), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run32("u100_7",   32'd100,        32'd7,          1'b0, 4'h3, 32'd14,         32'd2,          1'b0);
        run32("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 4'h5, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run32("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 4'h6, 32'hFFFF_FFFD,  32'd1,          1'b0);
        run32("dz_u",     32'h1234,       32'd0,          1'b0, 4'h7, 32'hFFFF_FFFF,  32'h1234,       1'b1);
        run32("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 4'h8, 32'h8000_0000,  32'd0,          1'b0);
        run32("dz_s_neg", 32'hFFFF_FFF9,  32'd0,          1'b1, 4'h9, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1);
        run32("u_big",    32'hFFFF_FFF9,  32'd2,          1'b0, 4'hA, 32'h7FFF_FFFC,  32'd1,          1'b0);
        run32("s_m8_m3",  32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 4'hB, 32'd2,          32'hFFFF_FFFE,  1'b0);
        run32("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 4'hC, 32'hFFFF_FFFF,  32'd0,          1'b0);

        run8("w8_255_16", 8'd255, 8'd16, 1'b0, 8'd15, 8'd15);
        run8("w8_ovf",    8'h80,  8'hFF, 1'b1, 8'h80, 8'h00);
        run8("w8_m7_2",   8'hF9,  8'h02, 1'b1, 8'hFD, 8'hFF);

        // Streamed operations with random back-pressure and mixed modes.
        for (int i = 0; i < 40; i++) begin
            ra[i] = (i == 7) ? 32'h8000_0000 : $urandom;
            case (i % 5)
                0:       rb[i] = 32'd0;
                1:       rb[i] = 32'hFFFF_FFFF;
                2:       rb[i] = 32'($urandom_range(1, 100));
                3:       rb[i] = $urandom;
                default: rb[i] = $urandom >> (i % 31);
            endcase
            rs[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; cyc = 0; held = 1'b0;
        hq = '0; hr = '0; ht = '0; hdz = 1'b0;
        while (got < 40 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            b32.out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 40) begin
                b32.in_valid  = 1'b1;
                b32.dividend  = ra[sent];
                b32.divisor   = rb[sent];
                b32.in_signed = rs[sent];
                b32.in_tag    = 4'(sent);
            end else begin
                b32.in_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("stall_valid", 64'(b32.out_valid), 64'd1);
                chk("stall_quot",  64'(b32.quotient), 64'(hq));
                chk("stall_rem",   64'(b32.remainder), 64'(hr));
                chk("stall_tag",   64'(b32.out_tag), 64'(ht));
                chk("stall_dz",    64'(b32.div_by_zero), 64'(hdz));
            end
            held = 1'b0;
            if (b32.out_valid) begin
                if (b32.out_ready) begin
                    chk("rnd_expected_pending", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rnd_tag",  64'(b32.out_tag), 64'(e[68:65]));
                        chk("rnd_dz",   64'(b32.div_by_zero), 64'(e[64]));
                        chk("rnd_quot", 64'(b32.quotient), 64'(e[63:32]));
                        chk("rnd_rem",  64'(b32.remainder), 64'(e[31:0]));
                        got++;
                    end
                end else begin
                    held = 1'b1;
                    hq   = b32.quotient;
                    hr   = b32.remainder;
                    ht   = b32.out_tag;
                    hdz  = b32.div_by_zero;
                end
            end
            if (b32.in_valid && b32.in_ready) begin
                sb.push_back({4'(sent), ref_div(ra[sent], rb[sent], rs[sent])});
                sent++;
            end
        end
        chk("rnd_results", 64'(got), 64'd40);
        @(negedge clk);
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Fill the pipe behind a stalled output, then reset mid-cycle.
        b32.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b32.in_valid  = 1'b1;
            b32.dividend  = 32'(1000 + i);
            b32.divisor   = 32'd3;
            b32.in_signed = 1'b0;
            b32.in_tag    = 4'(i + 1);
            @(negedge clk);
        end
        b32.in_valid = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("pre_rst_valid",    64'(b32.out_valid), 64'd1);
        chk("pre_rst_quot",     64'(b32.quotient), 64'd333);
        chk("stall_in_ready",   64'(b32.in_ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  64'(b32.out_valid), 64'd0);
        chk("async_rst_quot",   64'(b32.quotient), 64'd0);
        chk("async_rst_rem",    64'(b32.remainder), 64'd0);
        chk("async_rst_tag",    64'(b32.out_tag), 64'd0);
        chk("async_rst_ready",  64'(b32.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        nv = 0;
        repeat (60) begin
            @(negedge clk);
            if (b32.out_valid) nv++;
        end
        chk("no_stale_result", 64'(nv), 64'd0);
        run32("post_rst", 32'd1000, 32'd9, 1'b0, 4'hE, 32'd111, 32'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/div_pipe.md
DIV_PIPE -- requirements
Module: div_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 Parameter TAG_W, default 4, width of sideband tag carried alongside each operation.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation present on input bus.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 in_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with operands.
REQ-008 dividend  input  WIDTH  numerator.
REQ-009 divisor  input  WIDTH  denominator.
REQ-010 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result present on output bus.
REQ-012 out_ready  input  1  downstream accepts result this cycle.
REQ-013 quotient  output  WIDTH  division quotient.
REQ-014 remainder  output  WIDTH  division remainder.
REQ-015 out_tag  output  TAG_W  tag of the operation producing the result.
REQ-016 div_by_zero  output  1  result came from a zero divisor.

Function
REQ-017 Structure: input stage (sign capture, operand magnitudes), WIDTH restoring-division stages each producing one quotient bit MSB first, output stage (sign fix-up, flags); total WIDTH+2 register stages.
REQ-018 Handshake: transfer on in_valid&in_ready; result consumed on out_valid&out_ready.
REQ-019 Advance = out_ready | ~out_valid; in_ready = advance, combinational, no dependency on in_valid.
REQ-020 When advance=0, every stage (data, valid, tag, flags) holds; no operation lost or duplicated.
REQ-021 Latency: accepted operation appears on out_valid exactly WIDTH+2 cycles later when advance stays 1; each stall cycle adds one cycle.
REQ-022 Throughput: one operation per cycle while advance=1; per-stage valid bits propagate bubbles.
REQ-023 Outputs (quotient, remainder, out_tag, div_by_zero) stable while out_valid=1 and out_ready=0.
REQ-024 Each iteration stage: partial remainder WIDTH+1 bits; shift in next dividend bit; subtract divisor magnitude if no borrow, set quotient bit 1, else keep and set 0.
REQ-025 Unsigned mode: quotient = floor(dividend/divisor), remainder = dividend mod divisor.
REQ-026 Signed mode: magnitudes divided; quotient negated when operand signs differ; remainder carries dividend sign; quotient truncates toward zero.
REQ-027 Signed overflow (dividend = most-negative, divisor = -1): quotient = most-negative, remainder = 0, div_by_zero = 0.
REQ-028 Divisor zero, either mode: quotient = all ones, remainder = dividend unchanged, div_by_zero = 1.
REQ-029 Operations with different in_signed values interleave freely; mode travels with its operation.
REQ-030 Quotient/remainder values irrelevant when out_valid=0; out_tag likewise.

Reset
REQ-031 rst_n low: all stage valid bits, out_valid and div_by_zero clear to 0; quotient, remainder, out_tag clear to 0; in-flight operations discarded.
REQ-032 Reset asserted mid-operation: outputs go to reset values immediately (asynchronously); no result from before reset ever appears after release.
REQ-033 First rising edge after rst_n high: in_ready = 1, input accepted.

Verification
REQ-034 WIDTH=32, unsigned 100/7, tag 3, out_ready=1 -> after 34 cycles out_valid=1, quotient 14, remainder 2, out_tag 3.
REQ-035 WIDTH=32, signed -7/2 -> quotient -1 (0xFFFFFFFF)... corrected: quotient -3 (0xFFFFFFFD), remainder -1 (0xFFFFFFFF); signed 7/-2 -> quotient -3, remainder 1.
REQ-036 Divisor 0, dividend 0x1234 -> quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1; signed 0x80000000/-1 -> quotient 0x80000000, remainder 0.
REQ-037 Back-to-back 40 random operations with out_ready toggled pseudo-randomly -> results in order, matching reference model, tags intact, outputs stable during stalls.
REQ-038 Reset asserted with 10 operations in flight -> out_valid drops immediately; after release no stale result emerges; next operation returns after WIDTH+2 cycles.
REQ-039 WIDTH=8 build, unsigned 255/16 -> quotient 15, remainder 15, latency 10 cycles.
